l2_arbiter: RTL and testbench

Two-master request arbiter feeding the unified L2 cache. It accepts line-sized Wishbone-style requests from the L1 instruction cache (port I) and the L1 data cache (port D), and grants exactly one at a time. It forwards the granted request to the L2 slave port and returns the L2 `ack`/`rty` and read data to the granted master only. It sits between the split L1 caches and the L2 control/datapath.

---
 rtl/l2_arbiter.sv | 178 +++++++++++++++++
 tb/tb_l2_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter: two-master arbiter in front of the unified L2 cache.
// Grants one of the L1 instruction port (I) or L1 data port (D) at a time,
// forwards the granted request to the L2 slave port and routes the L2
// ack/rty/read data back to the granted master only.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_cyc/i_stb/i_we/i_addr/i_sel/i_wdata  -> port I request
//   i_rdata/i_ack/i_rty               <- port I response
//   d_*                               same as port I, for the data cache
//   l2_cyc/l2_stb/l2_we/l2_addr/l2_sel/l2_wdata -> L2 request
//   l2_rdata/l2_ack/l2_rty            <- L2 response
//   grant                             one-hot grant status, bit0 = I, bit1 = D
//
// Configuration macro:
//   L2_ARB_FIXED_PRIO_EN  defined   -> D always wins a conflict in IDLE
//                         undefined -> round-robin between I and D
//
// Every grant returns through IDLE, so the L2 never sees back-to-back strobes
// from different masters (the L2 acks hits combinationally).
module l2_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  // Port I
  input  logic                i_cyc,
  input  logic                i_stb,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_sel,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  output logic                i_rty,
  // Port D
  input  logic                d_cyc,
  input  logic                d_stb,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                d_rty,
  // L2 slave side
  output logic                l2_cyc,
  output logic                l2_stb,
  output logic                l2_we,
  output logic [ADDR_W-1:0]   l2_addr,
  output logic [DATA_W/8-1:0] l2_sel,
  output logic [DATA_W-1:0]   l2_wdata,
  input  logic [DATA_W-1:0]   l2_rdata,
  input  logic                l2_ack,
  input  logic                l2_rty,
  // Status
  output logic [1:0]          grant
);

  localparam int unsigned SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   prio_d;
  logic   req_i;
  logic   req_d;
  logic   l2_done;

  assign req_i   = i_cyc & i_stb;
  assign req_d   = d_cyc & d_stb;
  // rty wins over ack for the master, but either one ends the grant
  assign l2_done = l2_ack | l2_rty;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef L2_ARB_FIXED_PRIO_EN
  // D always wins a conflict
  assign prio_d = 1'b1;
`else
  // Round-robin priority: a completed grant hands priority to the other port;
  // an abort (cyc dropped without ack/rty) leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_d <= 1'b0;
    end else if ((state != ST_IDLE) && l2_done) begin
      prio_d <= (state == ST_GNT_I);
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (req_i && req_d) begin
          state_nxt = prio_d ? ST_GNT_D : ST_GNT_I;
        end else if (req_i) begin
          state_nxt = ST_GNT_I;
        end else if (req_d) begin
          state_nxt = ST_GNT_D;
        end
      end
      ST_GNT_I: begin
        if (l2_done || !i_cyc) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GNT_D: begin
        if (l2_done || !d_cyc) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output mux: driven purely from the registered state plus live master and
  // L2 signals; l2_stb never depends on l2_ack.
  always_comb begin
    grant    = 2'b00;
    l2_cyc   = 1'b0;
    l2_stb   = 1'b0;
    l2_we    = 1'b0;
    l2_addr  = '0;
    l2_sel   = SEL_W'(0);
    l2_wdata = '0;
    i_rdata  = '0;
    i_ack    = 1'b0;
    i_rty    = 1'b0;
    d_rdata  = '0;
    d_ack    = 1'b0;
    d_rty    = 1'b0;
    unique case (state)
      ST_GNT_I: begin
        grant    = 2'b01;
        l2_cyc   = i_cyc;
        l2_stb   = i_cyc & i_stb;
        l2_we    = i_we;
        l2_addr  = i_addr;
        l2_sel   = i_sel;
        l2_wdata = i_wdata;
        i_rdata  = l2_rdata;
        i_ack    = l2_ack;
        i_rty    = l2_rty;
      end
      ST_GNT_D: begin
        grant    = 2'b10;
        l2_cyc   = d_cyc;
        l2_stb   = d_cyc & d_stb;
        l2_we    = d_we;
        l2_addr  = d_addr;
        l2_sel   = d_sel;
        l2_wdata = d_wdata;
        d_rdata  = l2_rdata;
        d_ack    = l2_ack;
        d_rty    = l2_rty;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Testbench for l2_arbiter: cycle table of control vectors plus hand-written
// sequences for data routing, long L2 stalls and reset mid-grant.
module tb_l2_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned SEL_W  = DATA_W / 8;

`ifdef L2_ARB_FIXED_PRIO_EN
  localparam bit FX = 1'b1;
`else
  localparam bit FX = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              i_cyc, i_stb, i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [SEL_W-1:0]  i_sel;
  logic [DATA_W-1:0] i_wdata, i_rdata;
  logic              i_ack, i_rty;
  logic              d_cyc, d_stb, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [SEL_W-1:0]  d_sel;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              d_ack, d_rty;
  logic              l2_cyc, l2_stb, l2_we;
  logic [ADDR_W-1:0] l2_addr;
  logic [SEL_W-1:0]  l2_sel;
  logic [DATA_W-1:0] l2_wdata, l2_rdata;
  logic              l2_ack, l2_rty;
  logic [1:0]        grant;

  l2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_addr(i_addr), .i_sel(i_sel),
    .i_wdata(i_wdata), .i_rdata(i_rdata), .i_ack(i_ack), .i_rty(i_rty),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_rty(d_rty),
    .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_addr(l2_addr),
    .l2_sel(l2_sel), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata),
    .l2_ack(l2_ack), .l2_rty(l2_rty), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row: inputs for a cycle and the expected control outputs
  typedef struct {
    logic       ic, is, dc, ds, ack, rty;
    logic [1:0] g;
    logic       cyc, stb, ia, da, ir, dr;
  } vec_t;

  vec_t              tbl[$];
  vec_t              exp_q[$];
  logic [DATA_W-1:0] rdata_q[$];
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_cyc = 0; i_stb = 0; i_we = 0; i_addr = '0; i_sel = '0; i_wdata = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_addr = '0; d_sel = '0; d_wdata = '0;
    l2_ack = 0; l2_rty = 0; l2_rdata = '0;
  endtask

  task automatic add(input logic ic, is, dc, ds, ack, rty, input logic [1:0] g,
                     input logic cyc, stb, ia, da, ir, dr);
    vec_t v;
    v.ic = ic; v.is = is; v.dc = dc; v.ds = ds; v.ack = ack; v.rty = rty;
    v.g = g; v.cyc = cyc; v.stb = stb; v.ia = ia; v.da = da; v.ir = ir; v.dr = dr;
    tbl.push_back(v);
  endtask

  // Data word pushed when the L2 response is driven, popped when a master acks
  task automatic chk_rdata(input string nm, input logic [DATA_W-1:0] act);
    logic [DATA_W-1:0] e;
    if (rdata_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = rdata_q.pop_front();
      chk(nm, act, e);
    end
  endtask

  initial begin
    vec_t e;
    logic [DATA_W-1:0] rd;
    logic [7:0] act8, exp8;

    rst_n = 1'b0;
    idle_inputs();

    // Conflict-dependent rows: I wins under round-robin from reset, D if fixed
    add(1,1,1,1,0,0, 2'b00, 0,0,0,0,0,0);
    if (FX) add(1,1,1,1,1,0, 2'b10, 1,1,0,1,0,0); else add(1,1,1,1,1,0, 2'b01, 1,1,1,0,0,0);
    add(1,1,1,1,0,0, 2'b00, 0,0,0,0,0,0);
    add(1,1,1,1,1,0, 2'b10, 1,1,0,1,0,0);
    add(1,1,1,1,0,0, 2'b00, 0,0,0,0,0,0);
    if (FX) add(1,1,1,1,1,0, 2'b10, 1,1,0,1,0,0); else add(1,1,1,1,1,0, 2'b01, 1,1,1,0,0,0);
    add(0,0,0,0,0,0, 2'b00, 0,0,0,0,0,0);
    // Retry during GNT_I, D pending then granted
    add(1,1,0,0,0,0, 2'b00, 0,0,0,0,0,0);
    add(1,1,1,1,0,1, 2'b01, 1,1,0,0,1,0);
    add(1,1,1,1,0,0, 2'b00, 0,0,0,0,0,0);
    // D aborts, pending I granted next
    add(1,1,0,0,0,0, 2'b10, 0,0,0,0,0,0);
    add(1,1,0,0,0,0, 2'b00, 0,0,0,0,0,0);
    add(1,1,0,0,1,0, 2'b01, 1,1,1,0,0,0);
    // D abort keeps prio_d=1, so the following conflict goes to D
    add(0,0,1,1,0,0, 2'b00, 0,0,0,0,0,0);
    add(0,0,0,0,0,0, 2'b10, 0,0,0,0,0,0);
    add(1,1,1,1,0,0, 2'b00, 0,0,0,0,0,0);
    add(1,1,1,1,1,0, 2'b10, 1,1,0,1,0,0);
    // ack and rty together: both passed, grant ends
    add(1,1,0,0,0,0, 2'b00, 0,0,0,0,0,0);
    add(1,1,0,0,1,1, 2'b01, 1,1,1,0,1,0);
    // ack with simultaneous cyc drop counts as ack: priority flips to I
    add(0,0,1,1,0,0, 2'b00, 0,0,0,0,0,0);
    add(0,0,0,0,1,0, 2'b10, 0,0,0,1,0,0);
    add(1,1,1,1,0,0, 2'b00, 0,0,0,0,0,0);
    if (FX) add(1,1,1,1,1,0, 2'b10, 1,1,0,1,0,0); else add(1,1,1,1,1,0, 2'b01, 1,1,1,0,0,0);
    add(0,0,0,0,0,0, 2'b00, 0,0,0,0,0,0);

    // Reset state
    #12;
    chk("reset_grant", DATA_W'(grant), DATA_W'(0));
    chk("reset_l2", DATA_W'({l2_cyc, l2_stb, l2_we}), DATA_W'(0));
    chk("reset_acks", DATA_W'({i_ack, i_rty, d_ack, d_rty}), DATA_W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven cycles
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      i_cyc = tbl[k].ic; i_stb = tbl[k].is; d_cyc = tbl[k].dc; d_stb = tbl[k].ds;
      l2_ack = tbl[k].ack; l2_rty = tbl[k].rty;
      exp_q.push_back(tbl[k]);
      #1;
      e = exp_q.pop_front();
      act8 = {grant, l2_cyc, l2_stb, i_ack, d_ack, i_rty, d_rty};
      exp8 = {e.g, e.cyc, e.stb, e.ia, e.da, e.ir, e.dr};
      chk($sformatf("row%0d", k), DATA_W'(act8), DATA_W'(exp8));
    end

    // Single I read at 0x1230, L2 acks one cycle after the strobe
    @(negedge clk);
    idle_inputs();
    i_cyc = 1; i_stb = 1; i_addr = 16'h1230; i_sel = '1;
    i_wdata = {4{32'hA5A5_0001}};
    #1 chk("rd_idle", DATA_W'(grant), DATA_W'(0));
    @(negedge clk); #1;
    chk("rd_grant", DATA_W'(grant), DATA_W'(2'b01));
    chk("rd_addr", DATA_W'(l2_addr), DATA_W'(16'h1230));
    chk("rd_sel", DATA_W'(l2_sel), DATA_W'({SEL_W{1'b1}}));
    chk("rd_wdata", l2_wdata, {4{32'hA5A5_0001}});
    chk("rd_we", DATA_W'(l2_we), DATA_W'(0));
    @(negedge clk);
    rd = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h5555_AAAA};
    l2_ack = 1; l2_rdata = rd; rdata_q.push_back(rd);
    #1;
    chk("rd_iack", DATA_W'(i_ack), DATA_W'(1));
    chk_rdata("rd_irdata", i_rdata);
    chk("rd_dside", DATA_W'({d_ack, d_rty}), DATA_W'(0));
    chk("rd_drdata", d_rdata, '0);
    @(negedge clk);
    idle_inputs(); l2_rdata = {4{32'h1111_2222}};
    #1;
    chk("rd_after_grant", DATA_W'(grant), DATA_W'(0));
    chk("rd_after_rdata", i_rdata, '0);

    // D write miss stalled 20 cycles while I waits
    @(negedge clk);
    d_cyc = 1; d_stb = 1; d_we = 1; d_addr = 16'hBEE0; d_sel = '1; d_wdata = {4{32'hCAFE_F00D}};
    #1 chk("wr_idle", DATA_W'(grant), DATA_W'(0));
    @(negedge clk);
    i_cyc = 1; i_stb = 1; i_addr = 16'h0040;
    #1;
    chk("wr_addr", DATA_W'(l2_addr), DATA_W'(16'hBEE0));
    chk("wr_we", DATA_W'(l2_we), DATA_W'(1));
    chk("wr_wdata", l2_wdata, {4{32'hCAFE_F00D}});
    chk("wr_stall0", DATA_W'(grant), DATA_W'(2'b10));
    for (int c = 1; c < 20; c++) begin
      @(negedge clk); #1;
      chk($sformatf("wr_stall%0d", c), DATA_W'({grant, i_ack, d_ack}), DATA_W'(4'b1000));
    end
    @(negedge clk);
    rd = {4{32'h0BAD_CAFE}};
    l2_ack = 1; l2_rdata = rd; rdata_q.push_back(rd);
    #1;
    chk("wr_dack", DATA_W'({grant, d_ack, i_ack}), DATA_W'(4'b1010));
    chk_rdata("wr_drdata", d_rdata);
    @(negedge clk);
    l2_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    #1 chk("wr_turn_idle", DATA_W'(grant), DATA_W'(0));
    @(negedge clk); #1;
    chk("wr_then_i", DATA_W'(grant), DATA_W'(2'b01));
    @(negedge clk);
    l2_ack = 1;
    #1 chk("wr_i_ack", DATA_W'(i_ack), DATA_W'(1));
    @(negedge clk);
    idle_inputs();
    #1 chk("wr_end", DATA_W'(grant), DATA_W'(0));

    // Reset mid-GNT_D clears outputs asynchronously; first conflict then goes to I
    @(negedge clk);
    d_cyc = 1; d_stb = 1;
    @(negedge clk); #1;
    chk("rst_pre_grant", DATA_W'({grant, l2_cyc, l2_stb}), DATA_W'(4'b1011));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", DATA_W'({grant, l2_cyc, l2_stb, d_ack}), DATA_W'(0));
    @(negedge clk);
    i_cyc = 1; i_stb = 1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_idle", DATA_W'(grant), DATA_W'(0));
    @(negedge clk); #1;
    chk("rst_first_conflict", DATA_W'(grant), FX ? DATA_W'(2'b10) : DATA_W'(2'b01));
    @(negedge clk);
    idle_inputs();

    if (rdata_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", rdata_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
